// File: rtl/multi_key_beep.sv
// ---------------------------------------------------------------------------
// multi_key_beep
//   Debounces KEY_NUM active-low push keys and, on a debounced press, sounds a
//   buzzer for (index+1) bursts of BEEP_ON_CYC on / BEEP_OFF_CYC off. Presses
//   arriving while a sequence is running are flagged but otherwise ignored.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst    : synchronous active-high reset
//   key        : raw asynchronous keys, active-low
//   key_state  : debounced key levels, active-low
//   key_flag   : one-cycle pulse per channel on a debounced press
//   beep       : buzzer drive, 1 = sounding
//   busy       : 1 while a beep sequence is running
// ---------------------------------------------------------------------------
module multi_key_beep #(
    parameter int          KEY_NUM      = 4,
    parameter logic [19:0] CNT_MAX      = 20'd999_999,
    parameter logic [24:0] BEEP_ON_CYC  = 25'd5_000_000,
    parameter logic [24:0] BEEP_OFF_CYC = 25'd5_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_flag,
    output logic               beep,
    output logic               busy
);

    // Debounce counter only needs to reach CNT_MAX-1; keep at least 1 bit.
    localparam int DB_W = (CNT_MAX > 20'd2) ? $clog2(CNT_MAX) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(CNT_MAX - 20'd1);

    localparam logic [24:0] CYC_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int CYC_W = (CYC_MAX > 25'd2) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] ON_LAST  = CYC_W'(BEEP_ON_CYC - 25'd1);
    localparam logic [CYC_W-1:0] OFF_LAST = CYC_W'(BEEP_OFF_CYC - 25'd1);

    // Burst target is 1..KEY_NUM.
    localparam int BURST_W = (KEY_NUM > 1) ? $clog2(KEY_NUM + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2
    } state_t;

    logic [KEY_NUM-1:0] r_key_meta;
    logic [KEY_NUM-1:0] r_key_sync;
    logic [KEY_NUM-1:0] r_key_state;
    logic [KEY_NUM-1:0] r_key_flag;
    logic [DB_W-1:0]    r_db_cnt [KEY_NUM];

    state_t             r_fsm;
    logic [CYC_W-1:0]   r_cyc;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_target;
    logic               r_beep;
    logic               r_busy;

    logic               w_any_flag;
    logic [BURST_W-1:0] w_sel_n;

    // ---------------- synchronizer + per-channel debounce ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_key_meta  <= '1;
            r_key_sync  <= '1;
            r_key_state <= '1;
            r_key_flag  <= '0;
            for (int i = 0; i < KEY_NUM; i++) r_db_cnt[i] <= '0;
        end else begin
            r_key_meta <= key;
            r_key_sync <= r_key_meta;
            r_key_flag <= '0;
            for (int i = 0; i < KEY_NUM; i++) begin
                if (r_key_sync[i] == r_key_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    // Stable long enough: adopt the new level. Flag only
                    // presses, and in the same edge so it lines up with
                    // the first cycle key_state reads 0.
                    r_db_cnt[i]    <= '0;
                    r_key_state[i] <= r_key_sync[i];
                    r_key_flag[i]  <= ~r_key_sync[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest flagged channel wins: scan high to low so the last hit sticks.
    always_comb begin
        w_sel_n = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (r_key_flag[i]) w_sel_n = BURST_W'(i + 1);
        end
    end

    assign w_any_flag = |r_key_flag;

    // ---------------- beep sequencer ----------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fsm    <= IDLE;
            r_cyc    <= '0;
            r_burst  <= '0;
            r_target <= '0;
            r_beep   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_any_flag) begin
                        r_fsm    <= BEEP_ON;
                        r_target <= w_sel_n;
                        r_burst  <= BURST_W'(1);
                        r_cyc    <= '0;
                        r_beep   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                BEEP_ON: begin
                    if (r_cyc == ON_LAST) begin
                        r_fsm  <= BEEP_OFF;
                        r_cyc  <= '0;
                        r_beep <= 1'b0;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                BEEP_OFF: begin
                    if (r_cyc == OFF_LAST) begin
                        r_cyc <= '0;
                        if (r_burst == r_target) begin
                            r_fsm   <= IDLE;
                            r_burst <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_fsm   <= BEEP_ON;
                            r_burst <= r_burst + 1'b1;
                            r_beep  <= 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: begin
                    r_fsm  <= IDLE;
                    r_cyc  <= '0;
                    r_beep <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign key_state = r_key_state;
    assign key_flag  = r_key_flag;
    assign beep      = r_beep;
    assign busy      = r_busy;

endmodule

// File: tb/tb_multi_key_beep.sv
// ---------------------------------------------------------------------------
// tb_multi_key_beep
//   Scoreboard bench: stimulus predicts key_flag events and beep sequences
//   from the timing rules (press latency, burst count = index+1, presses
//   during a sequence ignored) and queues them; a monitor pops and compares
//   whenever the DUT shows a flag or starts a sequence, and checks the beep
//   waveform cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multi_key_beep;

    localparam int KN  = 4;
    localparam int CM  = 10;
    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int PER = ON + OFF;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [KN-1:0] key     = '1;
    logic [KN-1:0] key_state;
    logic [KN-1:0] key_flag;
    logic          beep;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } flag_ev_t;

    typedef struct {
        int start;
        int n;
    } seq_ev_t;

    flag_ev_t flag_q[$];
    seq_ev_t  seq_q[$];
    int       idle_from = 0;

    multi_key_beep #(
        .KEY_NUM     (KN),
        .CNT_MAX     (20'd10),
        .BEEP_ON_CYC (25'd4),
        .BEEP_OFF_CYC(25'd3)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key      (key),
        .key_state(key_state),
        .key_flag (key_flag),
        .beep     (beep),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 ns after the falling edge, away from both edges.
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    // A key driven low at count c is first sampled on edge c+1 and flags
    // CM+2 edges later. A sequence starts the cycle after the flag and only
    // if the sequencer is idle by then.
    task automatic predict(input logic [3:0] m, input int c);
        int fc, n;
        fc = c + CM + 2;
        flag_q.push_back('{fc, m});
        if (fc >= idle_from) begin
            n = lowest(m) + 1;
            seq_q.push_back('{fc + 1, n});
            idle_from = fc + 1 + PER * n;
        end
    endtask

    task automatic bounce(input logic [3:0] m);
        key = key & ~m; repeat (2) tick();
        key = key | m;  repeat (1) tick();
        key = key & ~m; repeat (3) tick();
        key = key | m;  repeat (2) tick();
    endtask

    task automatic press(input logic [3:0] m, input bit bnc, input int hold);
        if (bnc) bounce(m);
        key = key & ~m;
        predict(m, cyc);
        repeat (hold) tick();
        if (hold >= CM + 2) chk("key_state_pressed", key_state & m, 0);
    endtask

    task automatic release_keys(input logic [3:0] m, input int gap);
        key = key | m;
        repeat (gap) tick();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit       act;
        bit       stray;
        int       st, nb, rel;
        flag_ev_t fe;
        seq_ev_t  se;
        act = 0; stray = 0; st = 0; nb = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                act   = 0;
                stray = 0;
            end else begin
                if (key_flag != '0) begin
                    if (flag_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL flag_unexpected actual=%b required=0000 cyc=%0d", key_flag, cyc);
                    end else begin
                        fe = flag_q.pop_front();
                        chk("flag_cycle", cyc, fe.cyc);
                        chk("flag_mask", key_flag, fe.mask);
                    end
                end
                if (!act && !stray && busy) begin
                    chk("seq_pending", (seq_q.size() > 0), 1);
                    if (seq_q.size() > 0) begin
                        se = seq_q.pop_front();
                        chk("seq_start", cyc, se.start);
                        act = 1; st = cyc; nb = se.n;
                    end else begin
                        stray = 1;
                    end
                end
                if (stray) begin
                    if (!busy) stray = 0;
                end else if (act) begin
                    rel = cyc - st;
                    chk("seq_busy", busy, (rel < PER * nb));
                    chk("seq_beep", beep, (rel < PER * nb) && ((rel % PER) < ON));
                    if (rel >= PER * nb) act = 0;
                end else begin
                    chk("idle_beep", beep, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [3:0] m;
        int         c;

        sys_rst = 1'b1;
        key     = '1;
        repeat (3) tick();
        chk("rst_key_state", key_state, 4'hF);
        chk("rst_key_flag", key_flag, 4'h0);
        chk("rst_beep", beep, 0);
        chk("rst_busy", busy, 0);
        sys_rst = 1'b0;
        tick();

        // Bounce that never settles low.
        bounce(4'b0001);
        repeat (CM + 5) tick();
        chk("bounce_key_state", key_state, 4'hF);
        chk("bounce_busy", busy, 0);

        // Clean press ch0 (1 burst), ch2 (3 bursts), bounced press ch1.
        press(4'b0001, 0, CM + 12); release_keys(4'b0001, CM + 6);
        press(4'b0100, 0, CM + 30); release_keys(4'b0100, CM + 6);
        press(4'b0010, 1, CM + 12); release_keys(4'b0010, CM + 6);

        // Simultaneous ch1+ch3: index 1 wins (2 bursts).
        press(4'b1010, 0, CM + 20); release_keys(4'b1010, CM + 6);

        // ch3 pressed while ch2 sequence runs: flag only.
        press(4'b0100, 0, 5);
        press(4'b1000, 0, CM + 35);
        release_keys(4'b1100, CM + 6);

        // Random presses, some of which land during a running sequence.
        for (int it = 0; it < 12; it++) begin
            m = 4'($urandom_range(1, 15));
            press(m, bit'($urandom_range(0, 1)), CM + 3 + int'($urandom_range(0, 30)));
            release_keys(m, CM + 4 + int'($urandom_range(0, 40)));
        end
        repeat (40) tick();

        // Reset during the second burst of a ch2 sequence, key kept low.
        key = key & ~4'b0100;
        c = cyc;
        predict(4'b0100, c);
        repeat (CM + 2 + 9) tick();
        chk("pre_rst_beep", beep, 1);
        sys_rst = 1'b1;
        tick();
        chk("mid_rst_beep", beep, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_key_flag", key_flag, 4'h0);
        chk("mid_rst_key_state", key_state, 4'hF);
        sys_rst = 1'b0;
        idle_from = 0;
        predict(4'b0100, cyc);
        repeat (CM + 2 + 3 * PER + 6) tick();
        release_keys(4'b0100, CM + 10);

        chk("flag_q_empty", flag_q.size(), 0);
        chk("seq_q_empty", seq_q.size(), 0);
        chk("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_key_beep.md
MULTI_KEY_BEEP -- requirements
Module: multi_key_beep

Interface
REQ-001 The block SHALL have parameter KEY_NUM, default 4, meaning the number of independent key channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_MAX, default 20'd999_999, meaning the debounce stability window in clock cycles (20 ms at 50 MHz).
REQ-003 The block SHALL have parameter BEEP_ON_CYC, default 25'd5_000_000, meaning the beep-on length per burst in cycles.
REQ-004 The block SHALL have parameter BEEP_OFF_CYC, default 25'd5_000_000, meaning the beep-off gap per burst in cycles.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port key, input, KEY_NUM bits: raw asynchronous key inputs, active-low (0 = pressed).
REQ-008 The block SHALL have port key_state, output, KEY_NUM bits: debounced key levels, active-low.
REQ-009 The block SHALL have port key_flag, output, KEY_NUM bits: one-cycle pulse per channel on a debounced press (1->0).
REQ-010 The block SHALL have port beep, output, 1 bit: buzzer drive, 1 = sounding.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 while a beep sequence is in progress.

Function
REQ-012 Each key bit SHALL pass through a 2-flop synchronizer (key_sync) before any other use.
REQ-013 Each channel SHALL have an independent debounce counter of width $clog2(CNT_MAX); counter = 0 whenever key_sync equals key_state, otherwise increments by 1 each cycle.
REQ-014 When a channel's counter equals CNT_MAX-1 and key_sync still differs from key_state, key_state SHALL take key_sync on the next edge and the counter SHALL return to 0.
REQ-015 Any glitch returning key_sync to key_state before CNT_MAX consecutive differing cycles SHALL clear the counter and produce no state change and no key_flag.
REQ-016 key_flag[i] SHALL be registered and high for exactly the one cycle in which key_state[i] first reads 0 after a 1->0 update; releases (0->1) SHALL produce no flag.
REQ-017 Press latency SHALL be exactly CNT_MAX+2 rising edges from the first edge sampling key[i]=0 (stable) to key_flag[i]=1.
REQ-018 The beep controller SHALL be an FSM with states IDLE, BEEP_ON, BEEP_OFF.
REQ-019 In IDLE, if any key_flag is high, the FSM SHALL latch burst target N = (lowest set flag index)+1 and enter BEEP_ON next cycle; lower index wins on simultaneous flags.
REQ-020 In BEEP_ON, beep SHALL be 1 for exactly BEEP_ON_CYC cycles, then the FSM SHALL enter BEEP_OFF.
REQ-021 In BEEP_OFF, beep SHALL be 0 for exactly BEEP_OFF_CYC cycles; then, if the burst count has reached N, go to IDLE, else increment burst count and return to BEEP_ON.
REQ-022 A sequence for channel i SHALL therefore last (i+1)*(BEEP_ON_CYC+BEEP_OFF_CYC) cycles with busy=1 throughout and busy=0 in IDLE.
REQ-023 key_flag pulses arriving while busy=1 SHALL still appear on key_flag but SHALL NOT start, extend or queue a beep sequence.
REQ-024 beep and busy SHALL be registered outputs, glitch-free, decoded from FSM state.
REQ-025 Cycle counters SHALL be sized by $clog2 of their maximum and SHALL never wrap; reaching terminal count always forces the state transition.

Reset
REQ-026 While sys_rst=1 at a rising edge: key_sync and key_state SHALL be all-ones, debounce counters 0, key_flag 0, FSM IDLE, burst count 0, beep 0, busy 0.
REQ-027 Reset asserted mid-debounce or mid-sequence SHALL abort immediately with no residual flag or beep after release; a key held low through reset SHALL produce a flag CNT_MAX+2 edges after release.

Verification (KEY_NUM=4, CNT_MAX=10, BEEP_ON_CYC=4, BEEP_OFF_CYC=3)
REQ-028 Bounce: key[0] low 2 cycles, high 1, low 3, high 2 -> no key_flag, key_state stays 4'b1111, beep 0.
REQ-029 Clean press: key[0] held low -> key_flag[0] single pulse exactly 12 edges after first low sample; one burst: beep 1 for 4 cycles, 0 for 3; busy high 7 cycles.
REQ-030 Channel count: key[2] held low -> 3 bursts (4 on / 3 off each), busy high exactly 21 cycles, then IDLE.
REQ-031 Simultaneous: key[1] and key[3] fall same cycle -> both key_flag bits pulse same cycle; 2 bursts generated (index 1 wins).
REQ-032 Busy drop: key[3] press during channel-2 sequence -> key_flag[3] pulses, sequence length unchanged at 21 cycles, no sequence follows.
REQ-033 Reset mid-sequence: sys_rst=1 for 1 cycle during second BEEP_ON -> next cycle beep=0, busy=0, all outputs at reset values.
